// File: rtl/program_loader_if.sv
// Stream port of the boot loader: length-prefixed instruction words.
// Latency: none, pure wiring bundle.
// Backpressure: sink drives in_ready, source holds in_valid/in_data until taken.
interface program_loader_if #(
  parameter int INSTR_W = 9
) ();
  logic               in_valid;
  logic [INSTR_W-1:0] in_data;
  logic               in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/program_loader.sv
// Boot loader: takes a length word N then N instructions, writes imem from 0, then releases the core.
// Latency: one cycle from accepted beat to imem write; core released RELEASE_DELAY cycles after last write.
// Backpressure: in_ready is high only while awaiting length or loading; it never depends on in_valid.
module program_loader #(
  parameter int INSTR_W       = 9,
  parameter int ADDR_W        = 8,
  parameter int DEPTH         = 256,
  parameter int RELEASE_DELAY = 2
) (
  input  logic                clk,
  input  logic                reset,
  program_loader_if.slave     strm,
  input  logic                load_req,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [INSTR_W-1:0]  imem_wdata,
  output logic                cpu_reset,
  output logic                done,
  output logic                err
);

  // Wide enough to compare the length word against DEPTH and counter+1 without overflow.
  localparam int LW = INSTR_W + ADDR_W + 1;
  localparam int DW = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;

  typedef enum logic [2:0] {
    stLen,
    stLoad,
    stHold,
    stRun,
    stError
  } stateT;

  stateT              state, stateNxt;
  logic [ADDR_W-1:0]  wordCnt, wordCntNxt;
  logic [INSTR_W-1:0] lenN, lenNNxt;
  logic [DW-1:0]      delayCnt, delayCntNxt;
  logic               weNxt;
  logic [ADDR_W-1:0]  addrNxt;
  logic [INSTR_W-1:0] wdataNxt;
  logic               cpuResetNxt, doneNxt, errNxt;
  logic               inReady, beat, lastWord, badLen;

  // Ready is a pure function of the registered state.
  assign inReady       = (state == stLen) || (state == stLoad);
  assign strm.in_ready = inReady;
  assign beat          = strm.in_valid & inReady;
  assign lastWord      = ((LW'(wordCnt) + LW'(1)) == LW'(lenN));
  assign badLen        = (strm.in_data == '0) || (LW'(strm.in_data) > LW'(DEPTH));

  // Registered state and all outputs, so nothing downstream sees a glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= stLen;
      wordCnt    <= '0;
      lenN       <= '0;
      delayCnt   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_reset  <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= stateNxt;
      wordCnt    <= wordCntNxt;
      lenN       <= lenNNxt;
      delayCnt   <= delayCntNxt;
      imem_we    <= weNxt;
      imem_addr  <= addrNxt;
      imem_wdata <= wdataNxt;
      cpu_reset  <= cpuResetNxt;
      done       <= doneNxt;
      err        <= errNxt;
    end
  end

  // Next-state and next-output decode; write strobe defaults low, address/data hold.
  always_comb begin
    stateNxt    = state;
    wordCntNxt  = wordCnt;
    lenNNxt     = lenN;
    delayCntNxt = delayCnt;
    weNxt       = 1'b0;
    addrNxt     = imem_addr;
    wdataNxt    = imem_wdata;
    cpuResetNxt = cpu_reset;
    doneNxt     = done;
    errNxt      = err;
    case (state)
      stLen: begin
        if (beat) begin
          lenNNxt    = strm.in_data;
          wordCntNxt = '0;
          if (badLen) begin
            stateNxt = stError;
            errNxt   = 1'b1;
          end else begin
            stateNxt = stLoad;
          end
        end
      end
      stLoad: begin
        if (beat) begin
          weNxt      = 1'b1;
          addrNxt    = wordCnt;
          wdataNxt   = strm.in_data;
          wordCntNxt = wordCnt + ADDR_W'(1);
          if (lastWord) begin
            stateNxt    = stHold;
            delayCntNxt = '0;
          end
        end
      end
      stHold: begin
        // The final write pulse occupies the first HOLD cycle; release lands RELEASE_DELAY cycles after it.
        if (delayCnt == DW'(RELEASE_DELAY - 1)) begin
          stateNxt    = stRun;
          cpuResetNxt = 1'b0;
          doneNxt     = 1'b1;
        end else begin
          delayCntNxt = delayCnt + DW'(1);
        end
      end
      stRun: begin
        if (load_req) begin
          stateNxt    = stLen;
          cpuResetNxt = 1'b1;
          doneNxt     = 1'b0;
        end
      end
      stError: begin
        if (load_req) begin
          stateNxt = stLen;
          errNxt   = 1'b0;
        end
      end
      default: begin
        stateNxt = stLen;
      end
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed streams checked every cycle against an abstract loader model.
// Latency: model predicts write one cycle after each beat and release two cycles after the last write.
// Backpressure: model predicts in_ready from its own phase, never from the DUT.
module tb_program_loader;

  localparam int RD = 2;
  localparam int P_LEN = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_ERR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_req;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [8:0] imem_wdata;
  logic       cpu_reset, done, err;

  program_loader_if #(.INSTR_W(9)) strm ();

  program_loader #(
    .INSTR_W(9), .ADDR_W(8), .DEPTH(256), .RELEASE_DELAY(RD)
  ) dut (
    .clk(clk), .reset(reset), .strm(strm), .load_req(load_req),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int nVec = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: dut=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Abstract model: phase, words left to load, next address, cycles left before release.
  int         mPhase, mLeft, mAddr, mWait;
  logic       expWe;
  logic [7:0] expAddr;
  logic [8:0] expData;
  logic       expCpu, expDone, expErr;

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mPhase <= P_LEN; mLeft <= 0; mAddr <= 0; mWait <= 0;
      expWe <= 1'b0; expAddr <= '0; expData <= '0;
      expCpu <= 1'b1; expDone <= 1'b0; expErr <= 1'b0;
    end else begin
      expWe <= 1'b0;
      case (mPhase)
        P_LEN: if (strm.in_valid) begin
          if (int'(strm.in_data) == 0 || int'(strm.in_data) > 256) begin
            mPhase <= P_ERR; expErr <= 1'b1;
          end else begin
            mPhase <= P_LOAD; mLeft <= int'(strm.in_data); mAddr <= 0;
          end
        end
        P_LOAD: if (strm.in_valid) begin
          expWe <= 1'b1; expAddr <= mAddr[7:0]; expData <= strm.in_data;
          mAddr <= mAddr + 1; mLeft <= mLeft - 1;
          if (mLeft == 1) begin mPhase <= P_HOLD; mWait <= RD; end
        end
        P_HOLD: begin
          if (mWait == 1) begin mPhase <= P_RUN; expCpu <= 1'b0; expDone <= 1'b1; end
          else mWait <= mWait - 1;
        end
        P_RUN: if (load_req) begin mPhase <= P_LEN; expCpu <= 1'b1; expDone <= 1'b0; end
        P_ERR: if (load_req) begin mPhase <= P_LEN; expErr <= 1'b0; end
        default: mPhase <= P_LEN;
      endcase
    end
  end

  // Captured DUT memory image and timing bookkeeping for literal checks.
  logic [8:0] dutMem [256];
  int wrCnt = 0;
  int cyc = 0;
  int lastWeCyc = 0;
  int fallCyc = 0;
  logic prevCpu = 1'b1;

  // Every cycle: compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    cyc++;
    chk("imem_we", imem_we, expWe);
    chk("imem_addr", imem_addr, expAddr);
    chk("imem_wdata", imem_wdata, expData);
    chk("cpu_reset", cpu_reset, expCpu);
    chk("done", done, expDone);
    chk("err", err, expErr);
    chk("in_ready", strm.in_ready, (mPhase == P_LEN || mPhase == P_LOAD));
    if (imem_we === 1'b1) begin
      dutMem[imem_addr] = imem_wdata;
      wrCnt++;
      lastWeCyc = cyc;
    end
    if (prevCpu === 1'b1 && cpu_reset === 1'b0) fallCyc = cyc;
    prevCpu = cpu_reset;
  end

  task automatic beat(input logic [8:0] d);
    strm.in_valid = 1'b1;
    strm.in_data  = d;
    @(negedge clk); #1;
    strm.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    strm.in_valid = 1'b0;
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic reqPulse();
    load_req = 1'b1;
    @(negedge clk); #1;
    load_req = 1'b0;
  endtask

  int base;

  initial begin
    reset = 1'b1; load_req = 1'b0; strm.in_valid = 1'b0; strm.in_data = '0;
    repeat (2) begin @(negedge clk); #1; end
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_cpu", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", strm.in_ready, 1);
    reset = 1'b0;

    // N=3 back-to-back
    base = wrCnt;
    beat(9'd3); beat(9'h1A5); beat(9'h003); beat(9'h0FF);
    idle(4);
    chk("t1_writes", wrCnt - base, 3);
    chk("t1_mem0", dutMem[0], 9'h1A5);
    chk("t1_mem1", dutMem[1], 9'h003);
    chk("t1_mem2", dutMem[2], 9'h0FF);
    chk("t1_release_gap", fallCyc - lastWeCyc, 2);
    chk("t1_done", done, 1);

    // N=2 with a gap between data beats
    reqPulse();
    base = wrCnt;
    beat(9'd2); beat(9'h111);
    idle(1);
    chk("t2_ready_gap", strm.in_ready, 1);
    chk("t2_no_we_gap", imem_we, 0);
    idle(2);
    beat(9'h0AA);
    idle(4);
    chk("t2_writes", wrCnt - base, 2);
    chk("t2_mem0", dutMem[0], 9'h111);
    chk("t2_mem1", dutMem[1], 9'h0AA);

    // Bad lengths 0 and 257, then recovery with N=1
    reqPulse();
    base = wrCnt;
    beat(9'd0); idle(2);
    chk("t3_err0", err, 1);
    chk("t3_ready0", strm.in_ready, 0);
    chk("t3_cpu0", cpu_reset, 1);
    reqPulse();
    beat(9'd257); idle(2);
    chk("t3_err257", err, 1);
    chk("t3_nowrites", wrCnt - base, 0);
    reqPulse();
    chk("t3_err_clr", err, 0);
    beat(9'd1); beat(9'h055);
    idle(4);
    chk("t3_writes", wrCnt - base, 1);
    chk("t3_mem0", dutMem[0], 9'h055);
    chk("t3_done", done, 1);

    // Full 256-word image
    reqPulse();
    base = wrCnt;
    beat(9'd256);
    for (int i = 0; i < 256; i++) beat(9'(i));
    idle(7);
    chk("t4_writes", wrCnt - base, 256);
    chk("t4_mem0", dutMem[0], 9'h000);
    chk("t4_mem255", dutMem[255], 9'h0FF);
    chk("t4_done", done, 1);

    // Async reset mid-load, then restream
    reqPulse();
    beat(9'd4); beat(9'h1C1); beat(9'h1C2);
    chk("t5_pre_we", imem_we, 1);
    reset = 1'b1;
    #1;
    chk("t5_async_we", imem_we, 0);
    chk("t5_async_addr", imem_addr, 0);
    chk("t5_async_wdata", imem_wdata, 0);
    chk("t5_async_cpu", cpu_reset, 1);
    @(negedge clk); #1;
    reset = 1'b0;
    base = wrCnt;
    beat(9'd4); beat(9'h1D0); beat(9'h1D1); beat(9'h1D2); beat(9'h1D3);
    idle(4);
    chk("t5_writes", wrCnt - base, 4);
    chk("t5_mem0", dutMem[0], 9'h1D0);
    chk("t5_mem3", dutMem[3], 9'h1D3);
    chk("t5_done", done, 1);

    // Reload with in_valid held high across load_req
    base = wrCnt;
    load_req = 1'b1; strm.in_valid = 1'b1; strm.in_data = 9'd2;
    @(negedge clk); #1;
    chk("t6_cpu", cpu_reset, 1);
    chk("t6_done", done, 0);
    load_req = 1'b0;
    @(negedge clk); #1;
    beat(9'h0E1); beat(9'h0E2);
    idle(4);
    chk("t6_writes", wrCnt - base, 2);
    chk("t6_mem0", dutMem[0], 9'h0E1);
    chk("t6_mem1", dutMem[1], 9'h0E2);
    chk("t6_done_end", done, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
